// File: rtl/apb_master.sv
// APB initiator: decodes a single-outstanding core request onto one of four
// APB slots and runs the SETUP/ACCESS handshake with optional timeout.
module apb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  // core side
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  // APB side
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PENABLE,
  output logic [3:0]  PSEL,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      paddr_q, paddr_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic [3:0]       psel_q, psel_d;
  logic             penable_q, penable_d;
  logic [1:0]       slot_q, slot_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  // Address decode of the incoming request (only used while IDLE).
  logic       dec_hit;
  logic [1:0] dec_slot;

  assign dec_hit  = (addr[31:16] == BASE_ADDR[31:16]) && (addr[15:14] == 2'b00);
  assign dec_slot = addr[13:12];

  // Return path from the latched slot.
  logic [31:0] sel_prdata;
  logic        sel_pready;

  always_comb begin
    sel_prdata = PRDATA0;
    sel_pready = PREADY0;
    case (slot_q)
      2'd0: begin sel_prdata = PRDATA0; sel_pready = PREADY0; end
      2'd1: begin sel_prdata = PRDATA1; sel_pready = PREADY1; end
      2'd2: begin sel_prdata = PRDATA2; sel_pready = PREADY2; end
      2'd3: begin sel_prdata = PRDATA3; sel_pready = PREADY3; end
      default: ;
    endcase
  end

  logic timed_out;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    slot_d    = slot_q;
    hit_d     = hit_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          paddr_d   = addr;
          pwrite_d  = write;
          pwdata_d  = wdata;
          slot_d    = dec_slot;
          hit_d     = dec_hit;
          psel_d    = dec_hit ? (4'b0001 << dec_slot) : 4'b0000;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Miss, slave ready and timeout are mutually exclusive completions,
        // with slave ready taking precedence over a coincident timeout.
        if (!hit_q) begin
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (sel_pready) begin
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = pwrite_q ? 32'h0 : sel_prdata;
        end else if (timed_out) begin
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
        if (ready_d) begin
          psel_d    = 4'b0000;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        psel_d    = 4'b0000;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= S_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      slot_q    <= '0;
      hit_q     <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      slot_q    <= slot_d;
      hit_q     <= hit_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a transaction-level model predicts decode,
// completion latency, err and rdata for each request.
module tb_apb_master;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam int          TIMEOUT = 16;
  localparam int          LIMIT   = TIMEOUT + 30;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] prdata_v [4];
  logic        pready_v [4];

  int n_cmp = 0;
  int n_err = 0;
  bit rand_prdata = 1'b1;

  always #5 PCLK = ~PCLK;

  apb_master #(.BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA0(prdata_v[0]), .PRDATA1(prdata_v[1]),
    .PRDATA2(prdata_v[2]), .PRDATA3(prdata_v[3]),
    .PREADY0(pready_v[0]), .PREADY1(pready_v[1]),
    .PREADY2(pready_v[2]), .PREADY3(pready_v[3])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: window of four 4 KiB slots starting at BASE.
  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'h4000);
  endfunction

  function automatic int slot_of(input logic [31:0] a);
    return int'((a - BASE) >> 12);
  endfunction

  // Edges after the transfer-sampling edge until ready is seen high.
  function automatic int exp_edges(input logic [31:0] a, input int w);
    if (!in_window(a)) return 2;
    if (TIMEOUT != 0 && w >= TIMEOUT) return TIMEOUT + 1;
    return w + 2;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the ready cycle.
  // The selected slave raises PREADY after w ACCESS cycles.
  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input int w, input bit busy);
    bit          hit;
    int          slot;
    int          n;
    int          n_exp;
    bit          to;
    logic [3:0]  psel_exp;
    logic [31:0] rd_last;

    hit      = in_window(a);
    slot     = hit ? slot_of(a) : 0;
    psel_exp = hit ? (4'b0001 << slot) : 4'b0000;
    n_exp    = exp_edges(a, w);
    to       = hit && (TIMEOUT != 0) && (w >= TIMEOUT);
    rd_last  = '0;

    transfer = 1'b1;
    write    = wr;
    addr     = a;
    wdata    = wd;
    for (int i = 0; i < 4; i++) pready_v[i] = 1'($urandom);
    @(posedge PCLK);
    n = 0;
    while (1) begin
      @(negedge PCLK);
      if (n > 0 && ready === 1'b1) break;
      if (n >= LIMIT) break;
      if (n == 0) check("ready_low_setup", 32'(ready), 32'h0);
      check("psel", 32'(PSEL), 32'(psel_exp));
      check("penable", 32'(PENABLE), (n == 0) ? 32'h0 : 32'h1);
      check("paddr", PADDR, a);
      check("pwrite", 32'(PWRITE), 32'(wr));
      check("pwdata", PWDATA, wd);
      transfer = busy ? 1'($urandom) : 1'b0;
      if (transfer) begin
        addr  = $urandom;
        write = 1'($urandom);
        wdata = $urandom;
      end
      for (int i = 0; i < 4; i++) begin
        pready_v[i] = 1'($urandom);
        if (rand_prdata) prdata_v[i] = $urandom;
      end
      if (hit) pready_v[slot] = (n == 0) ? 1'($urandom) : ((n - 1) >= w);
      rd_last = prdata_v[slot];
      @(posedge PCLK);
      n++;
    end
    transfer = 1'b0;
    check("latency", 32'(n), 32'(n_exp));
    check("err", 32'(err), 32'(!hit || to));
    check("rdata", rdata, (hit && !to && !wr) ? rd_last : 32'h0);
    check("psel_done", 32'(PSEL), 32'h0);
    check("penable_done", 32'(PENABLE), 32'h0);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(posedge PCLK);
      @(negedge PCLK);
      check("idle_ready", 32'(ready), 32'h0);
      check("idle_psel", 32'(PSEL), 32'h0);
      check("idle_penable", 32'(PENABLE), 32'h0);
      for (int i = 0; i < 4; i++) pready_v[i] = 1'($urandom);
    end
  endtask

  // Reset asserted in the second ACCESS cycle of a slot-2 read.
  task automatic reset_mid_transfer();
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_2000; wdata = 32'h0;
    for (int i = 0; i < 4; i++) pready_v[i] = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK); transfer = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pre_penable", 32'(PENABLE), 32'h1);
    check("rst_pre_psel", 32'(PSEL), 32'h4);
    #1 PRESET = 1'b0;
    #1;
    check("rst_async_psel", 32'(PSEL), 32'h0);
    check("rst_async_penable", 32'(PENABLE), 32'h0);
    check("rst_async_ready", 32'(ready), 32'h0);
    check("rst_async_paddr", PADDR, 32'h0);
    for (int i = 0; i < 4; i++) pready_v[i] = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b1;
    repeat (5) begin
      @(posedge PCLK);
      @(negedge PCLK);
      check("rst_no_ready", 32'(ready), 32'h0);
      check("rst_no_psel", 32'(PSEL), 32'h0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          w;

    PRESET   = 1'b0;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    for (int i = 0; i < 4; i++) begin
      prdata_v[i] = '0;
      pready_v[i] = 1'b0;
    end
    repeat (2) @(negedge PCLK);
    check("reset_psel", 32'(PSEL), 32'h0);
    check("reset_penable", 32'(PENABLE), 32'h0);
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_paddr", PADDR, 32'h0);
    check("reset_pwdata", PWDATA, 32'h0);
    check("reset_pwrite", 32'(PWRITE), 32'h0);
    PRESET = 1'b1;
    @(negedge PCLK);

    // Write GPO, slave ready one cycle into ACCESS.
    run_txn(1'b1, 32'h1000_1004, 32'h0000_00A5, 1, 1'b0);
    idle_cycles(1);

    // Read slot 1 with a hostile value on slot 0.
    rand_prdata = 1'b0;
    prdata_v[0] = 32'hFFFF_FFFF;
    prdata_v[1] = 32'h0000_000F;
    prdata_v[2] = 32'h1234_5678;
    prdata_v[3] = 32'h8765_4321;
    run_txn(1'b0, 32'h1000_1000, 32'h0, 0, 1'b0);
    check("read_slot1_value", rdata, 32'h0000_000F);
    rand_prdata = 1'b1;

    // Decode misses, back-to-back.
    run_txn(1'b0, 32'h2000_0000, 32'h0, 0, 1'b0);
    run_txn(1'b1, 32'h1000_4000, 32'hDEAD_BEEF, 0, 1'b0);

    // Timeout on slot 2.
    run_txn(1'b0, 32'h1000_2000, 32'h0, 100, 1'b0);
    // PREADY coinciding with the last allowed ACCESS cycle wins.
    run_txn(1'b0, 32'h1000_2010, 32'h0, TIMEOUT - 1, 1'b0);

    // transfer pulsed while busy.
    run_txn(1'b1, 32'h1000_3008, 32'h0BAD_F00D, 3, 1'b1);
    idle_cycles(4);

    reset_mid_transfer();
    run_txn(1'b0, 32'h1000_0008, 32'h0, 2, 1'b0);

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = BASE + ($urandom & 32'h0000_3FFF);
        2:       a = BASE | ($urandom & 32'h0000_FFFF);
        default: a = $urandom;
      endcase
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 4)
                                     : $urandom_range(0, 3);
      run_txn(1'($urandom), a, $urandom, w, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
